// File: rtl/regfile_sb.sv
// Register file with write-back scoreboard: two bypassed read ports, busy tracking
// of outstanding writes for RAW/WAW hazard detection, and flush of pending tracking.
module regfile_sb #(
  parameter int unsigned W_DATA = 32,
  parameter int unsigned W_RD   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_i,
  input  logic [W_RD-1:0]   rd_num_i,
  input  logic [W_DATA-1:0] rd_data_i,
  input  logic [W_RD-1:0]   ra_num_i,
  input  logic [W_RD-1:0]   rb_num_i,
  output logic [W_DATA-1:0] ra_data_o,
  output logic [W_DATA-1:0] rb_data_o,
  output logic              ra_busy_o,
  output logic              rb_busy_o,
  input  logic              issue_i,
  input  logic [W_RD-1:0]   issue_rd_i,
  output logic              issue_busy_o,
  input  logic              flush_i,
  output logic              issue_err_o,
  output logic [W_RD:0]     pend_cnt_o
);

  localparam int unsigned NREG  = 2 ** W_RD;
  localparam int unsigned W_CNT = W_RD + 1;

  logic [W_DATA-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [W_CNT-1:0]  pend_cnt;
  logic [W_CNT-1:0]  pend_cnt_nxt;
  logic              issue_err;
  logic              issue_err_nxt;
  logic              byp_a;
  logic              byp_b;
  logic              byp_i;
  logic              accept;
  logic              clear;

  // Read ports: a same-cycle write-back is forwarded and counts as ready
  always_comb begin
    byp_a        = wb_i && (rd_num_i == ra_num_i);
    byp_b        = wb_i && (rd_num_i == rb_num_i);
    byp_i        = wb_i && (rd_num_i == issue_rd_i);
    ra_data_o    = byp_a ? rd_data_i : regs[ra_num_i];
    rb_data_o    = byp_b ? rd_data_i : regs[rb_num_i];
    ra_busy_o    = busy[ra_num_i] && !byp_a;
    rb_busy_o    = busy[rb_num_i] && !byp_b;
    issue_busy_o = busy[issue_rd_i] && !byp_i;
  end

  // Scoreboard next state; a set on the register being cleared wins
  always_comb begin
    busy_nxt      = busy;
    pend_cnt_nxt  = pend_cnt;
    issue_err_nxt = 1'b0;
    clear         = wb_i && busy[rd_num_i];
    accept        = issue_i && !issue_busy_o;
    if (flush_i) begin
      busy_nxt     = '0;
      pend_cnt_nxt = '0;
    end else begin
      if (clear) busy_nxt[rd_num_i] = 1'b0;
      if (accept) busy_nxt[issue_rd_i] = 1'b1;
      pend_cnt_nxt  = pend_cnt + W_CNT'(accept) - W_CNT'(clear);
      issue_err_nxt = issue_i && issue_busy_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      pend_cnt  <= '0;
      issue_err <= 1'b0;
    end else begin
      busy      <= busy_nxt;
      pend_cnt  <= pend_cnt_nxt;
      issue_err <= issue_err_nxt;
    end
  end

  // Register array; writes land regardless of busy state or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_i) begin
      regs[rd_num_i] <= rd_data_i;
    end
  end

  assign issue_err_o = issue_err;
  assign pend_cnt_o  = pend_cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: reset, bypass, scoreboard, WAW, fill/flush.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        wb_i;
  logic [4:0]  rd_num_i;
  logic [31:0] rd_data_i;
  logic [4:0]  ra_num_i;
  logic [4:0]  rb_num_i;
  logic [31:0] ra_data_o;
  logic [31:0] rb_data_o;
  logic        ra_busy_o;
  logic        rb_busy_o;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic        issue_busy_o;
  logic        flush_i;
  logic        issue_err_o;
  logic [5:0]  pend_cnt_o;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.W_DATA(32), .W_RD(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_i        (wb_i),
    .rd_num_i    (rd_num_i),
    .rd_data_i   (rd_data_i),
    .ra_num_i    (ra_num_i),
    .rb_num_i    (rb_num_i),
    .ra_data_o   (ra_data_o),
    .rb_data_o   (rb_data_o),
    .ra_busy_o   (ra_busy_o),
    .rb_busy_o   (rb_busy_o),
    .issue_i     (issue_i),
    .issue_rd_i  (issue_rd_i),
    .issue_busy_o(issue_busy_o),
    .flush_i     (flush_i),
    .issue_err_o (issue_err_o),
    .pend_cnt_o  (pend_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_i       = 1'b0;
    rd_num_i   = '0;
    rd_data_i  = '0;
    issue_i    = 1'b0;
    issue_rd_i = '0;
    flush_i    = 1'b0;
  endtask

  logic any_busy;

  initial begin
    rst = 1'b1;
    ra_num_i = '0;
    rb_num_i = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pend", 64'(pend_cnt_o), 64'd0);
    chk("reset_err", 64'(issue_err_o), 64'd0);
    chk("reset_ra_data", 64'(ra_data_o), 64'd0);
    rst = 1'b0;

    // Write r3=0x1234 and issue r3 together: write lands, r3 becomes busy
    wb_i = 1'b1; rd_num_i = 5'd3; rd_data_i = 32'h1234;
    issue_i = 1'b1; issue_rd_i = 5'd3;
    tick();
    idle();
    ra_num_i = 5'd3;
    #1;
    chk("pre_rst_data", 64'(ra_data_o), 64'h1234);
    chk("pre_rst_busy", 64'(ra_busy_o), 64'd1);
    chk("pre_rst_pend", 64'(pend_cnt_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_data", 64'(ra_data_o), 64'd0);
    chk("midrst_busy", 64'(ra_busy_o), 64'd0);
    chk("midrst_pend", 64'(pend_cnt_o), 64'd0);
    tick();
    rst = 1'b0;

    // Bypass
    wb_i = 1'b1; rd_num_i = 5'd7; rd_data_i = 32'hDEADBEEF; ra_num_i = 5'd7;
    #1;
    chk("bypass_same", 64'(ra_data_o), 64'hDEADBEEF);
    tick();
    idle();
    #1;
    chk("bypass_after", 64'(ra_data_o), 64'hDEADBEEF);

    // Scoreboard set / clear on r5
    issue_i = 1'b1; issue_rd_i = 5'd5; rb_num_i = 5'd5;
    #1;
    chk("r5_issue_busy", 64'(issue_busy_o), 64'd0);
    chk("r5_same_cycle_rb_busy", 64'(rb_busy_o), 64'd0);
    tick();
    idle();
    #1;
    chk("r5_busy", 64'(rb_busy_o), 64'd1);
    chk("r5_pend1", 64'(pend_cnt_o), 64'd1);
    wb_i = 1'b1; rd_num_i = 5'd5; rd_data_i = 32'h55;
    #1;
    chk("r5_wb_busy", 64'(rb_busy_o), 64'd0);
    chk("r5_wb_data", 64'(rb_data_o), 64'h55);
    chk("r5_wb_pend", 64'(pend_cnt_o), 64'd1);
    tick();
    idle();
    #1;
    chk("r5_pend0", 64'(pend_cnt_o), 64'd0);
    chk("r5_after_data", 64'(rb_data_o), 64'h55);

    // WAW reject on r9
    issue_i = 1'b1; issue_rd_i = 5'd9;
    tick();
    #1;
    chk("r9_waw_busy", 64'(issue_busy_o), 64'd1);
    chk("r9_no_err_yet", 64'(issue_err_o), 64'd0);
    tick();
    idle();
    #1;
    chk("r9_err", 64'(issue_err_o), 64'd1);
    chk("r9_err_pend", 64'(pend_cnt_o), 64'd1);
    tick();
    chk("r9_err_gone", 64'(issue_err_o), 64'd0);
    chk("r9_pend_still1", 64'(pend_cnt_o), 64'd1);
    // Clear and re-issue r9 in one cycle: accepted, busy held, count unchanged
    wb_i = 1'b1; rd_num_i = 5'd9; rd_data_i = 32'h99;
    issue_i = 1'b1; issue_rd_i = 5'd9;
    #1;
    chk("r9_wbiss_busy", 64'(issue_busy_o), 64'd0);
    tick();
    idle();
    ra_num_i = 5'd9;
    #1;
    chk("r9_wbiss_err", 64'(issue_err_o), 64'd0);
    chk("r9_wbiss_rbusy", 64'(ra_busy_o), 64'd1);
    chk("r9_wbiss_pend", 64'(pend_cnt_o), 64'd1);
    chk("r9_wbiss_data", 64'(ra_data_o), 64'h99);
    wb_i = 1'b1; rd_num_i = 5'd9; rd_data_i = 32'h9A;
    tick();
    idle();
    #1;
    chk("r9_cleared_pend", 64'(pend_cnt_o), 64'd0);

    // Fill all 32 registers
    for (int i = 0; i < 32; i++) begin
      issue_i = 1'b1; issue_rd_i = 5'(i);
      tick();
    end
    idle();
    ra_num_i = 5'd31;
    #1;
    chk("fill_pend", 64'(pend_cnt_o), 64'd32);
    chk("fill_r31_busy", 64'(ra_busy_o), 64'd1);
    // Flush with a write to r0 and a would-be rejected issue
    flush_i = 1'b1; wb_i = 1'b1; rd_num_i = 5'd0; rd_data_i = 32'hA;
    issue_i = 1'b1; issue_rd_i = 5'd4;
    tick();
    idle();
    ra_num_i = 5'd0;
    #1;
    chk("flush_pend", 64'(pend_cnt_o), 64'd0);
    chk("flush_err", 64'(issue_err_o), 64'd0);
    chk("flush_r0", 64'(ra_data_o), 64'hA);
    any_busy = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rb_num_i = 5'(i);
      #1;
      any_busy = any_busy | rb_busy_o;
    end
    chk("flush_all_busy", 64'(any_busy), 64'd0);

    // Write to a non-busy register
    tick();
    wb_i = 1'b1; rd_num_i = 5'd2; rd_data_i = 32'h77;
    tick();
    idle();
    ra_num_i = 5'd2;
    #1;
    chk("nb_data", 64'(ra_data_o), 64'h77);
    chk("nb_pend", 64'(pend_cnt_o), 64'd0);
    chk("nb_busy", 64'(ra_busy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

General-purpose register file with integrated write-back scoreboard, sitting between decode and execute. Accepts the execute stage's write-back port (`wb`/`rd_num`/`rd_data`) and serves two combinational read ports to decode with same-cycle write bypass. Tracks registers with an outstanding write so decode can detect RAW/WAW hazards and stall; a flush discards all pending-write tracking.

## Interface
Parameters:
- `W_DATA`, 32, register width (equals `WORD`)
- `W_RD`, 5, register-number width (equals `W_RD`); `NREG = 2**W_RD` registers

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  reset, asynchronous, active-high
- `wb_i`  in  1  write enable from execute
- `rd_num_i`  in  `W_RD`  write register number
- `rd_data_i`  in  `W_DATA`  write data
- `ra_num_i`, `rb_num_i`  in  `W_RD` each  read port A/B register numbers
- `ra_data_o`, `rb_data_o`  out  `W_DATA` each  read data, combinational
- `ra_busy_o`, `rb_busy_o`  out  1 each  source has an outstanding write not yet available
- `issue_i`  in  1  decode issues an instruction that will write `issue_rd_i`
- `issue_rd_i`  in  `W_RD`  destination of the issued instruction
- `issue_busy_o`  out  1  `issue_rd_i` currently busy (WAW check), combinational
- `flush_i`  in  1  clear all busy bits
- `issue_err_o`  out  1  registered one-cycle pulse: illegal issue to a busy register
- `pend_cnt_o`  out  `W_RD+1`  number of busy registers

## Operation
- State: `regs[NREG]` of `W_DATA`; `busy[NREG]`; `pend_cnt`; `issue_err`.
- Write: `wb_i=1` writes `rd_data_i` into `regs[rd_num_i]` at posedge, independent of busy/flush. All registers incl. r0 are ordinary and writable.
- Read: `rX_data_o = (wb_i && rd_num_i==rX_num_i) ? rd_data_i : regs[rX_num_i]`.
- Busy read: `rX_busy_o = busy[rX_num_i] && !(wb_i && rd_num_i==rX_num_i)` (bypassed value is ready).
- `issue_busy_o` uses the same rule on `issue_rd_i`.
- Clear event: `wb_i && busy[rd_num_i]`. A `wb_i` to a non-busy register writes data only; no busy/count change.
- Accept event: `issue_i && !issue_busy_o`. Sets `busy[issue_rd_i]`.
- Reject event: `issue_i && issue_busy_o` -> `issue_err_o`=1 next cycle; busy unchanged; no count change.
- Same register cleared and accepted in one cycle: busy stays 1 (set wins), count unchanged.
- `pend_cnt` next = `pend_cnt + accept - clear`; equals popcount(busy) at all times; max `NREG`, never wraps.
- `flush_i=1`: next cycle all busy=0, `pend_cnt`=0, `issue_err_o`=0; overrides accept/reject/clear in that cycle. Write of `rd_data_i` still performed.
- Reset (any time, incl. mid-operation): all `regs`=0, all busy=0, `pend_cnt_o`=0, `issue_err_o`=0; outstanding writes forgotten. Read outputs then reflect zeros (or bypass).

## Timing
- Read data/busy and `issue_busy_o`: zero latency, combinational from inputs and state.
- Written value visible from array the cycle after `wb_i`; visible via bypass in the same cycle.
- Busy set visible on read ports the cycle after accept; issue and read of same register in one cycle returns not-busy (decode handles intra-bundle dependency).
- `issue_err_o`, `pend_cnt_o`: registered, update one cycle after the event.
- Reset asynchronous: outputs take reset values immediately on `rst` rise, held while high; first update on first posedge after deassert.

## Test plan
- Reset mid-run with r3=0x1234, busy r3: assert `rst` between edges -> `ra_data_o`(r3)=0, `ra_busy_o`=0, `pend_cnt_o`=0 immediately.
- Bypass: `wb_i`=1, `rd_num_i`=7, `rd_data_i`=0xDEADBEEF, `ra_num_i`=7 -> `ra_data_o`=0xDEADBEEF same cycle; next cycle with `wb_i`=0 still 0xDEADBEEF.
- Scoreboard: issue r5 -> next cycle `rb_busy_o`(r5)=1, `pend_cnt_o`=1; `wb_i` r5 data 0x55 -> that cycle `rb_busy_o`=0, data 0x55; next cycle `pend_cnt_o`=0.
- WAW: issue r9, then issue r9 again (no wb) -> `issue_err_o`=1 for exactly one cycle, `pend_cnt_o` stays 1; same cycle wb r9 + issue r9 -> no error, busy remains 1, count 1.
- Fill/flush: issue all 32 registers on 32 cycles -> `pend_cnt_o`=32; `flush_i` together with `wb_i` r0=0xA -> next cycle count 0, all busy 0, r0=0xA.
- Non-busy write: `wb_i` r2=0x77 with r2 not busy -> data written, `pend_cnt_o` unchanged (no underflow from 0).
